cp_insert: RTL and testbench
============================

Name: cp_insert

Overview:
- OFDM TX cyclic-prefix inserter; sits between the IFFT output and the TX sample interface.
- Buffers one D-sample time-domain symbol in a ping-pong RAM.
- Emits the last CP samples, then all D samples: D+CP output beats per symbol.
- Transmit-side counterpart of the RX delay-line/correlator path.

Parameters:
- WIDTH, 32, sample width (I/Q packed).
- D, 64, symbol length in samples; must equal 2^B.
- B, 6, address width, log2(D).
- CP, 16, cyclic-prefix length; legal range 1..D.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- in_val  in  1  input sample valid.
- in_dat  in  WIDTH  input sample; IFFT order, index 0 first.
- in_rdy  out  1  input can accept; transfer occurs when in_val & in_rdy.
- out_rdy  in  1  downstream ready.
- out_val  out  1  out_dat valid; transfer occurs when out_val & out_rdy.
- out_dat  out  WIDTH  output sample.
- out_sop  out  1  high with the first CP sample of a symbol.
- out_eop  out  1  high with body sample D-1 of a symbol.

Behaviour:
- Storage: 2 banks x D x WIDTH RAM; bank_full[1:0] flags.
  - Write side: wr_bank, wr_adr[B-1:0].
  - Read side: rd_bank, rd_adr[B-1:0].
- Reset (rst=1 at edge):
  - bank_full=0, wr_bank=rd_bank=0, wr_adr=rd_adr=0, FSM=IDLE.
  - out_val=0, out_sop=0, out_eop=0, out_dat=0.
  - in_rdy=0 while rst is high.
  - Reset mid-operation discards all buffered and partial symbols; no stale output after release.
- Write side:
  - in_rdy = ~rst & ~bank_full[wr_bank], combinational.
  - On accept: ram[wr_bank][wr_adr] <= in_dat; wr_adr++.
  - When wr_adr==D-1 on accept: set bank_full[wr_bank], toggle wr_bank; wr_adr wraps to 0.
  - in_val gaps allowed anywhere; partial symbol held indefinitely.
- Output register advance: load permitted when adv = ~out_val | out_rdy.
  - When !adv, out_dat/out_sop/out_eop/out_val hold stable.
- Read FSM, states IDLE, PFX, BODY:
  - IDLE: if bank_full[rd_bank] & adv:
    - load ram[rd_bank][D-CP], out_sop=1, out_val=1.
    - rd_adr=D-CP+1 mod D; go to PFX, or BODY with rd_adr=0 if CP==1.
  - Otherwise in IDLE, adv clears out_val/out_sop/out_eop.
  - PFX: on adv, load ram[rd_bank][rd_adr], rd_adr++.
    - After loading index D-1 (prefix end): rd_adr=0, go to BODY.
  - BODY: on adv, load ram[rd_bank][rd_adr], rd_adr++.
    - At index D-1: out_eop=1, clear bank_full[rd_bank], toggle rd_bank.
    - Then: if the other bank is already full, continue directly in PFX with no bubble (start index D-CP with out_sop); else go to IDLE.
  - out_sop/out_eop are single-beat, aligned with their sample.
- RAM read must be synchronous-compatible:
  - Implementer may register the read address.
  - Visible latency rule below must hold regardless.
- Latency: if the last input sample (index D-1) is accepted at edge t, with read side idle and out_rdy=1, the first CP sample is presented at edge t+2.
- Throughput:
  - out_rdy held 1 with banks kept filled: exactly D+CP consecutive beats per symbol, zero gap between symbols.
  - Input stalls (in_rdy=0) only when both banks are full.
- Simultaneous set (write side completing bank X) and clear (read side finishing bank Y != X) in the same cycle: both take effect.
  - The same bank cannot be set and cleared in one cycle.
- Wrap-around: all address counters are modulo D; CP==D outputs the whole symbol twice.

Test Plan:
- Single symbol, in_dat=0..63, out_rdy=1 -> 80 beats: 48..63 then 0..63; out_sop on 48, out_eop on the second 63; first out_val 2 cycles after the last accept.
- Three back-to-back symbols (base 0x100, 0x200, 0x300), in_val=1 continuous, out_rdy=1 -> 240 output beats, no out_val gaps after the first; in_rdy drops low while both banks full.
- Random out_rdy (50%) over 4 symbols -> sequence identical to scoreboard; out_dat/out_sop/out_eop stable whenever out_val & !out_rdy.
- Random in_val gaps (30%) -> correct content; output idles between symbols; out_sop only at symbol starts.
- rst asserted mid-PFX of symbol 1 with symbol 2 half written -> next edge out_val=0, in_rdy=0 during reset; after release, a fresh symbol 0..63 yields a clean 48..63,0..63 with no residue.
- Builds with CP=1 and CP=D=64 -> outputs 63,0..63 and 0..63,0..63 respectively, with correct sop/eop.

Source files
------------

// File: rtl/cp_insert.sv
// OFDM TX cyclic-prefix inserter: ping-pong buffers one D-sample symbol and
// replays its last CP samples followed by the full symbol (D+CP beats).
module cp_insert #(
    parameter int WIDTH = 32,
    parameter int D     = 64,
    parameter int B     = 6,
    parameter int CP    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_val,
    input  logic [WIDTH-1:0] in_dat,
    output logic             in_rdy,
    input  logic             out_rdy,
    output logic             out_val,
    output logic [WIDTH-1:0] out_dat,
    output logic             out_sop,
    output logic             out_eop
);
    typedef enum logic [1:0] {IDLE, PFX, BODY} state_t;

    localparam logic [B-1:0] ADR_LAST  = B'(D - 1);
    localparam logic [B-1:0] PFX_FIRST = B'(D - CP);
    localparam logic [B-1:0] PFX_NEXT  = B'(D - CP + 1);

    logic [WIDTH-1:0] ram [2*D];
    logic [1:0]       bank_full_q, bank_full_d;
    logic             wr_bank_q, rd_bank_q;
    logic [B-1:0]     wr_adr_q, rd_adr_q;
    state_t           state_q;

    // Stage 1 holds the synchronous RAM read; the output register is stage 2.
    logic             s1_val_q, s1_sop_q, s1_eop_q;
    logic [WIDTH-1:0] s1_dat_q;

    logic             adv, s1_adv, wr_acc, wr_done, rd_issue, rd_done;
    logic [B-1:0]     rd_sel_adr;

    assign in_rdy     = ~rst & ~bank_full_q[wr_bank_q];
    assign wr_acc     = in_val & in_rdy;
    assign wr_done    = wr_acc & (wr_adr_q == ADR_LAST);
    assign adv        = ~out_val | out_rdy;
    assign s1_adv     = ~s1_val_q | adv;
    assign rd_issue   = s1_adv & ((state_q != IDLE) | bank_full_q[rd_bank_q]);
    assign rd_done    = s1_adv & (state_q == BODY) & (rd_adr_q == ADR_LAST);
    assign rd_sel_adr = (state_q == IDLE) ? PFX_FIRST : rd_adr_q;

    // Write side only ever completes an empty bank and read side only drains a
    // full one, so a set and a clear in the same cycle never hit the same bank.
    always_comb begin
        bank_full_d = bank_full_q;
        if (wr_done) bank_full_d[wr_bank_q] = 1'b1;
        if (rd_done) bank_full_d[rd_bank_q] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_full_q <= '0;
            wr_bank_q   <= 1'b0;
            wr_adr_q    <= '0;
        end else begin
            bank_full_q <= bank_full_d;
            if (wr_acc) begin
                wr_adr_q <= wr_adr_q + 1'b1;
                if (wr_done) wr_bank_q <= ~wr_bank_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) ram[{wr_bank_q, wr_adr_q}] <= in_dat;
    end

    always_ff @(posedge clk) begin
        if (rd_issue) s1_dat_q <= ram[{rd_bank_q, rd_sel_adr}];
    end

    // After the last body read the FSM drops to IDLE, which re-arms on the
    // very next cycle if the other bank is full, so back-to-back symbols
    // stream without a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rd_bank_q <= 1'b0;
            rd_adr_q  <= '0;
            s1_val_q  <= 1'b0;
            s1_sop_q  <= 1'b0;
            s1_eop_q  <= 1'b0;
            out_val   <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_dat   <= '0;
        end else begin
            if (s1_adv) begin
                s1_val_q <= rd_issue;
                s1_sop_q <= 1'b0;
                s1_eop_q <= 1'b0;
                case (state_q)
                    IDLE: begin
                        if (bank_full_q[rd_bank_q]) begin
                            s1_sop_q <= 1'b1;
                            rd_adr_q <= PFX_NEXT;
                            state_q  <= (CP == 1) ? BODY : PFX;
                        end
                    end
                    PFX: begin
                        rd_adr_q <= rd_adr_q + 1'b1;
                        if (rd_adr_q == ADR_LAST) state_q <= BODY;
                    end
                    BODY: begin
                        rd_adr_q <= rd_adr_q + 1'b1;
                        if (rd_adr_q == ADR_LAST) begin
                            s1_eop_q  <= 1'b1;
                            rd_bank_q <= ~rd_bank_q;
                            state_q   <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
            if (adv) begin
                out_val <= s1_val_q;
                out_sop <= s1_val_q & s1_sop_q;
                out_eop <= s1_val_q & s1_eop_q;
                if (s1_val_q) out_dat <= s1_dat_q;
            end
        end
    end

endmodule

// File: tb/tb_cp_insert.sv
// Bench for cp_insert: three instances (CP=16, 1, 64) each checked against a
// symbol-level scoreboard built from the accepted input samples.
module tb_cp_insert;
    localparam int WIDTH = 32;
    localparam int D     = 64;
    localparam int B     = 6;
    localparam int NI    = 3;
    localparam int CP0   = 16;

    logic clk = 1'b0;
    logic rst;
    logic [NI-1:0]    in_val;
    logic [NI-1:0]    in_rdy, out_val, out_sop, out_eop;
    logic [NI-1:0]    out_rdy = '1;
    logic [WIDTH-1:0] in_dat  [NI];
    logic [WIDTH-1:0] out_dat [NI];

    int n_chk = 0, n_fail = 0, cyc = 0;
    int qsz [NI];
    int rdy_mode = 1;
    int first_cyc = 0, last_cyc = 0, nbeats = 0, acc_cyc = 0;
    bit stall_seen = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        out_rdy[0]   = (rdy_mode == 2) ? ($urandom_range(1) == 1) : (rdy_mode == 1);
        out_rdy[2:1] = 2'b11;
    end

    for (genvar g = 0; g < NI; g++) begin : gi
        localparam int CPG = (g == 0) ? CP0 : (g == 1) ? 1 : D;

        cp_insert #(.WIDTH(WIDTH), .D(D), .B(B), .CP(CPG)) dut (
            .clk    (clk),
            .rst    (rst),
            .in_val (in_val[g]),
            .in_dat (in_dat[g]),
            .in_rdy (in_rdy[g]),
            .out_rdy(out_rdy[g]),
            .out_val(out_val[g]),
            .out_dat(out_dat[g]),
            .out_sop(out_sop[g]),
            .out_eop(out_eop[g])
        );

        logic [WIDTH+1:0] eq [$];
        logic [WIDTH-1:0] sym [D];
        int               cnt = 0;
        bit               held = 0;
        logic [WIDTH+2:0] hold_v;

        always @(negedge clk) begin
            logic [WIDTH+1:0] e;
            if (rst) begin
                cnt  = 0;
                held = 0;
                eq.delete();
            end else begin
                if (held)
                    check($sformatf("hold%0d", g), {out_val[g], out_sop[g], out_eop[g], out_dat[g]}, hold_v);
                held   = out_val[g] && !out_rdy[g];
                hold_v = {out_val[g], out_sop[g], out_eop[g], out_dat[g]};
                if (out_val[g] && out_rdy[g]) begin
                    if (g == 0) begin
                        if (nbeats == 0) first_cyc = cyc;
                        last_cyc = cyc;
                        nbeats++;
                    end
                    check($sformatf("beat_expected%0d", g), eq.size() > 0, 1);
                    if (eq.size() > 0) begin
                        e = eq.pop_front();
                        check($sformatf("dat%0d", g), out_dat[g], e[WIDTH-1:0]);
                        check($sformatf("sop%0d", g), out_sop[g], e[WIDTH+1]);
                        check($sformatf("eop%0d", g), out_eop[g], e[WIDTH]);
                    end
                end
                if (in_val[g] && in_rdy[g]) begin
                    if (g == 0) acc_cyc = cyc;
                    sym[cnt] = in_dat[g];
                    cnt++;
                    if (cnt == D) begin
                        // Expected symbol: tail of length CPG, then the whole symbol.
                        for (int k = 0; k < D + CPG; k++) begin
                            if (k < CPG) eq.push_back({k == 0, 1'b0, sym[D-CPG+k]});
                            else         eq.push_back({1'b0, k == D + CPG - 1, sym[k-CPG]});
                        end
                        cnt = 0;
                    end
                end
                if (g == 0 && in_val[0] && !in_rdy[0]) stall_seen = 1;
            end
            qsz[g] = eq.size();
        end
    end

    task automatic send_sym(input int g, input logic [WIDTH-1:0] base, input int gap, input int n);
        int t;
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(99) < gap) begin
                in_val[g] = 1'b0;
                @(posedge clk); #1;
            end
            in_val[g] = 1'b1;
            in_dat[g] = base + WIDTH'(i);
            t = 0;
            @(negedge clk);
            while (!in_rdy[g] && t < 5000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 5000) check("in_rdy_timeout", 0, 1);
            @(posedge clk); #1;
        end
        in_val[g] = 1'b0;
    endtask

    task automatic wait_drain(input int g, input int budget);
        int t;
        t = 0;
        @(negedge clk);
        while ((qsz[g] != 0 || out_val[g]) && t < budget) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("drain%0d", g), t < budget, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        rst    = 1'b1;
        in_val = '0;
        for (int g = 0; g < NI; g++) in_dat[g] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_val", out_val, 0);
        check("rst_out_sop", out_sop, 0);
        check("rst_out_eop", out_eop, 0);
        check("rst_out_dat", out_dat[0], 0);
        check("rst_in_rdy", in_rdy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rel_in_rdy", in_rdy, 3'b111);
        @(posedge clk); #1;

        // Single symbol 0..63, latency and beat count.
        nbeats = 0;
        send_sym(0, 0, 0, D);
        wait_drain(0, 400);
        check("latency", first_cyc - acc_cyc, 3);
        check("beats1", nbeats, D + CP0);

        // Three back-to-back symbols, continuous input and output.
        nbeats = 0;
        stall_seen = 0;
        send_sym(0, 'h100, 0, D);
        send_sym(0, 'h200, 0, D);
        send_sym(0, 'h300, 0, D);
        wait_drain(0, 1000);
        check("beats3", nbeats, 3 * (D + CP0));
        check("gapless", last_cyc - first_cyc + 1, 3 * (D + CP0));
        check("in_stall_seen", stall_seen, 1);

        // Random downstream backpressure.
        rdy_mode = 2;
        repeat (4) send_sym(0, $urandom, 0, D);
        wait_drain(0, 3000);
        rdy_mode = 1;

        // Random input gaps.
        repeat (3) send_sym(0, $urandom, 30, D);
        wait_drain(0, 3000);

        // Reset mid-prefix with the next symbol half written.
        rdy_mode = 0;
        send_sym(0, 'h400, 0, D);
        send_sym(0, 'h500, 0, D / 2);
        rdy_mode = 1;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_in_rdy", in_rdy[0], 0);
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_out_val", out_val[0], 0);
        @(posedge clk); #1;
        rst = 1'b0;
        nbeats = 0;
        send_sym(0, 0, 0, D);
        wait_drain(0, 400);
        check("post_rst_beats", nbeats, D + CP0);

        // Boundary prefix lengths.
        send_sym(1, 0, 0, D);
        wait_drain(1, 400);
        send_sym(2, 0, 0, D);
        wait_drain(2, 400);

        for (int g = 0; g < NI; g++) check($sformatf("left_over%0d", g), qsz[g], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
